temp_scan_ctrl: RTL and testbench

Scan controller that time-shares one external 8-bit temperature ADC between NCH sensor channels. It issues sample requests on a periodic tick and converts each raw code to integer °C at 0.5 °C/LSB. It averages 2^AVG_LOG2 samples per channel, publishes one averaged reading per channel, and maintains a per-channel over-temperature alarm with hysteresis. It sits between the ADC interface and the system monitor/register block.

---
 rtl/temp_scan_pkg.sv | 24 ++
 rtl/temp_alarm_hyst.sv | 40 ++++
 rtl/temp_scan_ctrl.sv | 165 ++++++++++++++++
 tb/tb_temp_scan_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/temp_scan_pkg.sv
// rtl/temp_scan_pkg.sv - shared types and constants for the temperature scan controller
package temp_scan_pkg;

    // Scan sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACC  = 2'd2,
        PUB  = 2'd3
    } state_t;

    // Raw ADC code to degrees C: 0.5 degC per LSB, so drop one bit
    localparam int CONV_SHIFT = 1;

    // Default averaging depth and matching accumulator width
    localparam int AVG_LOG2_DEF = 2;
    localparam int ACC_W        = 7 + AVG_LOG2_DEF;

    // Accumulator width for any averaging depth: 7-bit samples summed 2^n times
    function automatic int acc_width(input int avg_log2);
        return 7 + avg_log2;
    endfunction

endpackage

// File: rtl/temp_alarm_hyst.sv
// rtl/temp_alarm_hyst.sv - one over-temperature flag with set/clear hysteresis
module temp_alarm_hyst
    import temp_scan_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       we_i,
    input  logic [7:0] avg_i,
    input  logic [7:0] thr_hi_i,
    input  logic [7:0] thr_lo_i,
    output logic       alarm_o
);

    logic alarm_q;
    logic alarm_d;

    // Set above the high threshold, clear below the low one, hold in between
    always_comb begin
        alarm_d = alarm_q;
        if (we_i) begin
            if (avg_i > thr_hi_i) begin
                alarm_d = 1'b1;
            end else if (avg_i < thr_lo_i) begin
                alarm_d = 1'b0;
            end
        end
    end

    // Flag register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= alarm_d;
        end
    end

    assign alarm_o = alarm_q;

endmodule

// File: rtl/temp_scan_ctrl.sv
// rtl/temp_scan_ctrl.sv - time-shared ADC scan: tick pacing, averaging, publish and alarms
module temp_scan_ctrl
    import temp_scan_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int CH_W     = 2,
    parameter int AVG_LOG2 = AVG_LOG2_DEF,
    parameter int TICK_DIV = 16,
    parameter int TIMEOUT  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic [7:0]      thr_hi,
    input  logic [7:0]      thr_lo,
    output logic            adc_req,
    output logic [CH_W-1:0] adc_ch,
    input  logic            adc_ack,
    input  logic [7:0]      adc_data,
    output logic            temp_valid,
    output logic [CH_W-1:0] temp_ch,
    output logic [7:0]      temp_out,
    output logic [NCH-1:0]  alarm,
    output logic            timeout_err
);

    localparam int AW = acc_width(AVG_LOG2);
    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int SW = AVG_LOG2 + 1;

    localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [WW-1:0]   WD_LAST   = WW'(TIMEOUT - 1);
    localparam logic [SW-1:0]   SMP_LAST  = SW'((1 << AVG_LOG2) - 1);
    localparam logic [CH_W-1:0] CH_LAST   = CH_W'(NCH - 1);

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_cnt_q;
    logic            tick;
    logic [WW-1:0]   wd_q, wd_d;
    logic [CH_W-1:0] ch_q, ch_d, ch_next;
    logic [AW-1:0]   acc_q, acc_d, acc_sum;
    logic [SW-1:0]   smp_q, smp_d;
    logic [6:0]      sample_q, sample_d, conv;
    logic [7:0]      temp_q, temp_d;
    logic [CH_W-1:0] tch_q, tch_d;
    logic            to_c;

    assign tick    = (tick_cnt_q == TICK_LAST);
    assign conv    = 7'(adc_data >> CONV_SHIFT);
    assign ch_next = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
    assign acc_sum = acc_q + AW'(sample_q);

    // Free-running sample pacing; parked at zero while scanning is disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q <= '0;
        end else if (!enable || tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
        end
    end

    // Sequencer and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            wd_q     <= '0;
            ch_q     <= '0;
            acc_q    <= '0;
            smp_q    <= '0;
            sample_q <= '0;
            temp_q   <= '0;
            tch_q    <= '0;
        end else begin
            state_q  <= state_d;
            wd_q     <= wd_d;
            ch_q     <= ch_d;
            acc_q    <= acc_d;
            smp_q    <= smp_d;
            sample_q <= sample_d;
            temp_q   <= temp_d;
            tch_q    <= tch_d;
        end
    end

    // Next-state logic: request, accumulate, publish; the reading is staged in ACC
    // so temp_out is already valid in the PUB cycle
    always_comb begin
        state_d  = state_q;
        wd_d     = wd_q;
        ch_d     = ch_q;
        acc_d    = acc_q;
        smp_d    = smp_q;
        sample_d = sample_q;
        temp_d   = temp_q;
        tch_d    = tch_q;
        to_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick && enable) begin
                    wd_d    = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (adc_ack) begin
                    sample_d = conv;
                    state_d  = ACC;
                end else if (wd_q == WD_LAST) begin
                    // Abandon this channel's partial average and move on
                    to_c    = 1'b1;
                    acc_d   = '0;
                    smp_d   = '0;
                    ch_d    = ch_next;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ACC: begin
                acc_d = acc_sum;
                if (smp_q == SMP_LAST) begin
                    temp_d  = {1'b0, 7'(acc_sum >> AVG_LOG2)};
                    tch_d   = ch_q;
                    state_d = PUB;
                end else begin
                    smp_d   = smp_q + 1'b1;
                    state_d = IDLE;
                end
            end
            PUB: begin
                acc_d   = '0;
                smp_d   = '0;
                ch_d    = ch_next;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign adc_req     = (state_q == REQ);
    assign adc_ch      = ch_q;
    assign temp_valid  = (state_q == PUB);
    assign temp_ch     = tch_q;
    assign temp_out    = temp_q;
    assign timeout_err = to_c;

    // One hysteresis flag per channel, written only when that channel publishes
    for (genvar g = 0; g < NCH; g++) begin : g_alarm
        temp_alarm_hyst u_hyst (
            .clk      (clk),
            .rst      (rst),
            .we_i     (temp_valid && (ch_q == CH_W'(g))),
            .avg_i    (temp_q),
            .thr_hi_i (thr_hi),
            .thr_lo_i (thr_lo),
            .alarm_o  (alarm[g])
        );
    end

endmodule

// File: tb/tb_temp_scan_ctrl.sv
// tb/tb_temp_scan_ctrl.sv - self-checking bench for temp_scan_ctrl
module tb_temp_scan_ctrl;

    localparam int NCH      = 4;
    localparam int CH_W     = 2;
    localparam int AVG_LOG2 = 2;
    localparam int TICK_DIV = 16;
    localparam int TIMEOUT  = 8;
    localparam int NSMP     = 1 << AVG_LOG2;

    logic            clk = 1'b0;
    logic            rst;
    logic            enable;
    logic [7:0]      thr_hi, thr_lo;
    logic            adc_req;
    logic [CH_W-1:0] adc_ch;
    logic            adc_ack;
    logic [7:0]      adc_data;
    logic            temp_valid;
    logic [CH_W-1:0] temp_ch;
    logic [7:0]      temp_out;
    logic [NCH-1:0]  alarm;
    logic            timeout_err;

    always #5 clk = ~clk;

    temp_scan_ctrl #(
        .NCH(NCH), .CH_W(CH_W), .AVG_LOG2(AVG_LOG2), .TICK_DIV(TICK_DIV), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .thr_hi(thr_hi), .thr_lo(thr_lo),
        .adc_req(adc_req), .adc_ch(adc_ch), .adc_ack(adc_ack), .adc_data(adc_data),
        .temp_valid(temp_valid), .temp_ch(temp_ch), .temp_out(temp_out),
        .alarm(alarm), .timeout_err(timeout_err)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state
    int cyc, m_phase, m_free_at, m_age, m_ch, m_sum, m_n;
    int m_pub_cyc, m_pub_ch, m_pub_avg, m_temp, m_tch;
    bit m_in_req;
    bit [NCH-1:0] m_alarm;

    // Stimulus configuration for the ADC responder
    int ack_delay;
    bit [NCH-1:0] noack_mask;
    bit late_ack, late_ack_next;
    int raw_q[$];

    // Observations of the DUT
    int log_ch[$], log_temp[$], log_cyc[$], log_alarm[$];
    int req_ch_q[$], req_len_q[$];
    int to_cnt, req_cyc_cnt, first_req_cyc, cur_len;
    bit prev_tv, prev_req;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic void model_reset();
        cyc = 0; m_phase = 0; m_free_at = 0; m_age = 0; m_ch = 0; m_sum = 0; m_n = 0;
        m_pub_cyc = -1; m_pub_ch = 0; m_pub_avg = 0; m_temp = 0; m_tch = 0;
        m_in_req = 0; m_alarm = '0; late_ack_next = 0;
        prev_tv = 0; prev_req = 0; cur_len = 0; first_req_cyc = -1;
    endfunction

    function automatic void clear_logs();
        log_ch.delete(); log_temp.delete(); log_cyc.delete(); log_alarm.delete();
        req_ch_q.delete(); req_len_q.delete(); to_cnt = 0;
    endfunction

    // One clock cycle: drive inputs at negedge, compare, advance the model
    task automatic step();
        bit ack;
        int data;
        bit tick;
        ack = 0;
        data = 0;
        if (m_in_req && !noack_mask[m_ch] && m_age == ack_delay) begin
            ack = 1;
            data = (raw_q.size() > 0) ? raw_q.pop_front() : 100;
        end else if (late_ack_next) begin
            ack = 1;
            data = 255;
            late_ack_next = 0;
        end
        adc_ack = ack;
        adc_data = data[7:0];
        #1;
        if (cyc == m_pub_cyc) begin
            m_temp = m_pub_avg;
            m_tch = m_pub_ch;
        end
        check("adc_req", adc_req, m_in_req);
        if (m_in_req) check("adc_ch", adc_ch, m_ch);
        check("temp_valid", temp_valid, cyc == m_pub_cyc);
        check("temp_out", temp_out, m_temp);
        check("temp_ch", temp_ch, m_tch);
        check("alarm", alarm, m_alarm);
        check("timeout_err", timeout_err, m_in_req && !ack && m_age == TIMEOUT - 1);

        if (prev_tv) log_alarm.push_back(int'(alarm));
        prev_tv = temp_valid;
        if (temp_valid) begin
            log_ch.push_back(int'(temp_ch));
            log_temp.push_back(int'(temp_out));
            log_cyc.push_back(cyc);
        end
        if (timeout_err) to_cnt++;
        if (adc_req) begin
            req_cyc_cnt++;
            if (first_req_cyc < 0) first_req_cyc = cyc;
            if (!prev_req) req_ch_q.push_back(int'(adc_ch));
            cur_len++;
        end else if (prev_req) begin
            req_len_q.push_back(cur_len);
            cur_len = 0;
        end
        prev_req = adc_req;

        if (cyc == m_pub_cyc) begin
            if (m_pub_avg > int'(thr_hi)) m_alarm[m_pub_ch] = 1'b1;
            else if (m_pub_avg < int'(thr_lo)) m_alarm[m_pub_ch] = 1'b0;
        end
        tick = enable && (m_phase == TICK_DIV - 1);
        m_phase = enable ? (m_phase + 1) % TICK_DIV : 0;
        if (m_in_req) begin
            if (ack) begin
                m_in_req = 0;
                m_sum += data / 2;
                m_n++;
                if (m_n == NSMP) begin
                    m_pub_cyc = cyc + 2;
                    m_pub_avg = m_sum / NSMP;
                    m_pub_ch = m_ch;
                    m_ch = (m_ch + 1) % NCH;
                    m_sum = 0;
                    m_n = 0;
                    m_free_at = cyc + 3;
                end else begin
                    m_free_at = cyc + 2;
                end
            end else if (m_age == TIMEOUT - 1) begin
                m_in_req = 0;
                m_sum = 0;
                m_n = 0;
                m_ch = (m_ch + 1) % NCH;
                m_free_at = cyc + 1;
                if (late_ack) late_ack_next = 1;
            end else begin
                m_age++;
            end
        end else if (cyc >= m_free_at && tick) begin
            m_in_req = 1;
            m_age = 0;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_until_logs(input int n, input int budget);
        int k;
        k = 0;
        while (log_ch.size() < n && k < budget) begin
            step();
            k++;
        end
        check("pub_count", log_ch.size(), n);
        repeat (2) step();
    endtask

    function automatic int qat(input int q[$], input int i);
        return (q.size() > i) ? q[i] : -1;
    endfunction

    initial begin
        int k;
        rst = 1; enable = 0; thr_hi = 8'd200; thr_lo = 8'd0;
        adc_ack = 0; adc_data = 0;
        ack_delay = 1; noack_mask = '0; late_ack = 0;
        model_reset();
        clear_logs();
        repeat (3) @(negedge clk);
        #1;
        check("rst_adc_req", adc_req, 0);
        check("rst_temp_valid", temp_valid, 0);
        check("rst_temp_out", temp_out, 0);
        check("rst_alarm", alarm, 0);
        check("rst_timeout_err", timeout_err, 0);
        @(negedge clk);
        rst = 0;
        enable = 1;
        model_reset();

        // Basic scan: every sample 100 -> 50 degC, channels in order
        run_until_logs(5, 400);
        check("a_first_req", first_req_cyc, 16);
        check("a_first_pub", qat(log_cyc, 0), 67);
        check("a_spacing", qat(log_cyc, 1) - qat(log_cyc, 0), 64);
        for (int i = 0; i < 5; i++) begin
            check("a_ch", qat(log_ch, i), i % NCH);
            check("a_temp", qat(log_temp, i), 50);
        end

        // Hysteresis on ch1: 65 sets, 56 holds, 50 clears
        thr_hi = 8'd60; thr_lo = 8'd55;
        clear_logs();
        repeat (4) raw_q.push_back(130);
        repeat (12) raw_q.push_back(100);
        repeat (4) raw_q.push_back(112);
        repeat (12) raw_q.push_back(100);
        repeat (4) raw_q.push_back(100);
        run_until_logs(9, 9 * 64 + 40);
        check("b_ch1_a", qat(log_ch, 0), 1);
        check("b_temp_65", qat(log_temp, 0), 65);
        check("b_alarm_set", qat(log_alarm, 0), 32'h2);
        check("b_alarm_other", qat(log_alarm, 1), 32'h2);
        check("b_temp_56", qat(log_temp, 4), 56);
        check("b_alarm_hold", qat(log_alarm, 4), 32'h2);
        check("b_temp_50", qat(log_temp, 8), 50);
        check("b_alarm_clr", qat(log_alarm, 8), 32'h0);

        // Timeout on ch2, late ack ignored, scan resumes on ch3
        thr_hi = 8'd200; thr_lo = 8'd0;
        clear_logs();
        noack_mask = 4'b0100;
        late_ack = 1;
        run_until_logs(1, 200);
        noack_mask = '0;
        late_ack = 0;
        check("c_to_cnt", to_cnt, 1);
        check("c_req_ch2", qat(req_ch_q, 0), 2);
        check("c_req_len", qat(req_len_q, 0), TIMEOUT);
        check("c_next_ch", qat(req_ch_q, 1), 3);
        check("c_pub_ch", qat(log_ch, 0), 3);

        // Enable gating mid-average on ch0: 101,103 | pause | 100,102 -> 50
        clear_logs();
        raw_q.push_back(101);
        raw_q.push_back(103);
        k = 0;
        while (m_n < 2 && k < 100) begin
            step();
            k++;
        end
        check("d_two_samples", m_n, 2);
        enable = 0;
        step();
        req_cyc_cnt = 0;
        repeat (60) step();
        check("d_no_req", req_cyc_cnt, 0);
        raw_q.push_back(100);
        raw_q.push_back(102);
        enable = 1;
        run_until_logs(1, 120);
        check("d_ch", qat(log_ch, 0), 0);
        check("d_temp", qat(log_temp, 0), 50);

        // Set alarm[1], then reset in the middle of the ch2 request
        thr_hi = 8'd40; thr_lo = 8'd30;
        clear_logs();
        run_until_logs(1, 120);
        check("e_alarm", qat(log_alarm, 0), 32'h2);
        k = 0;
        while (!m_in_req && k < 40) begin
            step();
            k++;
        end
        adc_ack = 0;
        #1;
        check("e_pre_req", adc_req, 1);
        #2;
        rst = 1;
        #1;
        check("e_rst_req", adc_req, 0);
        check("e_rst_alarm", alarm, 0);
        check("e_rst_temp", temp_out, 0);
        check("e_rst_tv", temp_valid, 0);
        @(negedge clk);
        rst = 0;
        model_reset();
        clear_logs();
        repeat (20) step();
        check("e_first_req", first_req_cyc, 16);
        check("e_first_ch", qat(req_ch_q, 0), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
